// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver.
// Digits are time-multiplexed with a blanking gap at the start of every slot.
// New values go into shadow registers and reach the active set only at a frame boundary.
module seg7_scan_driver #(
   parameter int unsigned DIGIT_TICKS  = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic        gclk,
   input  logic        reset,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blank_in,
   input  logic        load,
   output logic [7:0]  seg,
   output logic [3:0]  an,
   output logic        frame_tick
);

   localparam int unsigned CW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
   localparam logic [CW-1:0] CNT_LAST      = CW'(DIGIT_TICKS - 1);
   localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_CYCLES - 1);

   typedef enum logic {
      BLANK,
      ON
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic          slot_end, frame_end;

   logic [15:0]   sh_value, act_value;
   logic [3:0]    sh_dp, act_dp;
   logic [3:0]    sh_blank, act_blank;

   logic [7:0]    seg_nxt;
   logic [3:0]    an_nxt;
   logic [3:0]    nib;

   function automatic logic [6:0] hex7(input logic [3:0] d);
      case (d)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   assign slot_end  = (cnt == CNT_LAST);
   assign frame_end = slot_end && (idx == 2'd3);

   // Slot counter and digit index; the index advances on every slot wrap.
   always_ff @(posedge gclk) begin
      if (reset) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // Shadow capture on load; active set transfers at frame end, taking a coincident load directly.
   always_ff @(posedge gclk) begin
      if (reset) begin
         sh_value  <= '0;
         sh_dp     <= '0;
         sh_blank  <= '0;
         act_value <= '0;
         act_dp    <= '0;
         act_blank <= '0;
      end else begin
         if (load) begin
            sh_value <= value;
            sh_dp    <= dp_in;
            sh_blank <= blank_in;
         end
         if (frame_end) begin
            act_value <= load ? value    : sh_value;
            act_dp    <= load ? dp_in    : sh_dp;
            act_blank <= load ? blank_in : sh_blank;
         end
      end
   end

   // Slot phase register.
   always_ff @(posedge gclk) begin
      if (reset) state <= BLANK;
      else       state <= state_nxt;
   end

   // Phase transitions: blanking gap first, then the lit portion until the slot wraps.
   always_comb begin
      state_nxt = state;
      case (state)
         BLANK:   if (cnt == CNT_BLANK_END) state_nxt = ON;
         ON:      if (slot_end)             state_nxt = BLANK;
         default: state_nxt = BLANK;
      endcase
   end

   // Display pattern for the current phase and digit.
   always_comb begin
      seg_nxt = 8'hFF;
      an_nxt  = 4'b1111;
      nib     = act_value[{idx, 2'b00} +: 4];
      if (state == ON && !act_blank[idx]) begin
         seg_nxt = {~act_dp[idx], hex7(nib)};
         an_nxt  = ~(4'b0001 << idx);
      end
   end

   // Registered outputs; frame_tick marks the first cycle the new active set is visible.
   always_ff @(posedge gclk) begin
      if (reset) begin
         seg        <= 8'hFF;
         an         <= 4'b1111;
         frame_tick <= 1'b0;
      end else begin
         seg        <= seg_nxt;
         an         <= an_nxt;
         frame_tick <= frame_end;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with an 8-cycle slot and a 2-cycle blank.
module tb_seg7_scan_driver;

   logic        gclk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  blank_in = '0;
   logic [7:0]  seg;
   logic [3:0]  an;
   logic        frame_tick;

   seg7_scan_driver #(.DIGIT_TICKS(8), .BLANK_CYCLES(2)) dut (
      .gclk       (gclk),
      .reset      (reset),
      .value      (value),
      .dp_in      (dp_in),
      .blank_in   (blank_in),
      .load       (load),
      .seg        (seg),
      .an         (an),
      .frame_tick (frame_tick)
   );

   always #5 gclk = ~gclk;

   typedef struct packed {
      logic [7:0] seg;
      logic [3:0] an;
      logic       ft;
   } exp_t;

   typedef struct {
      logic [15:0]     value;
      logic [3:0]      dp;
      logic [3:0]      blank;
      int              load_off;
      logic [3:0][7:0] exp_seg;
      logic [3:0]      lit_mask;
   } vec_t;

   exp_t q[$];
   vec_t vecs[4];

   int n_vec = 0;
   int n_err = 0;

   // Reference model state; m_t is the cycle index since the last reset edge.
   int          m_t = 0;
   logic [15:0] m_sh_v, m_act_v;
   logic [3:0]  m_sh_dp, m_act_dp, m_sh_bl, m_act_bl;

   function automatic logic [6:0] ref_hex7(input logic [3:0] d);
      logic [6:0] t [16];
      t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return t[d];
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s t=%0d got=%h exp=%h", name, m_t, got, exp);
      end
   endtask

   // Predict the outputs produced by the coming edge and update the model.
   task automatic model_push();
      exp_t       e;
      int         p, pc, pi;
      logic [3:0] nib;
      if (reset) begin
         e = '{seg: 8'hFF, an: 4'hF, ft: 1'b0};
         m_t = 0;
         m_sh_v = '0; m_sh_dp = '0; m_sh_bl = '0;
         m_act_v = '0; m_act_dp = '0; m_act_bl = '0;
      end else begin
         p  = m_t;
         pc = p % 8;
         pi = (p / 8) % 4;
         e  = '{seg: 8'hFF, an: 4'hF, ft: (p % 32 == 31)};
         if (pc >= 2 && !m_act_bl[pi]) begin
            nib   = m_act_v[pi*4 +: 4];
            e.seg = {~m_act_dp[pi], ref_hex7(nib)};
            e.an  = ~(4'b0001 << pi);
         end
         if (p % 32 == 31) begin
            m_act_v  = load ? value    : m_sh_v;
            m_act_dp = load ? dp_in    : m_sh_dp;
            m_act_bl = load ? blank_in : m_sh_bl;
         end
         if (load) begin
            m_sh_v = value; m_sh_dp = dp_in; m_sh_bl = blank_in;
         end
         m_t++;
      end
      q.push_back(e);
   endtask

   task automatic cyc();
      exp_t e;
      model_push();
      @(posedge gclk);
      #1;
      e = q.pop_front();
      check("seg", seg, e.seg);
      check("an", {4'h0, an}, {4'h0, e.an});
      check("frame_tick", {7'h0, frame_tick}, {7'h0, e.ft});
      check("an_onehot", {7'h0, ($countones(~an) <= 1)}, 8'h01);
   endtask

   task automatic run_to(input int off);
      for (int i = 0; i < 64 && (m_t % 32) != off; i++) cyc();
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
      value = v; dp_in = d; blank_in = b; load = 1'b1;
      cyc();
      load = 1'b0;
   endtask

   // Run one whole frame and compare each digit's lit pattern with table constants.
   task automatic check_frame(input logic [3:0][7:0] exp_seg, input logic [3:0] lit_mask);
      int t0, rel, s;
      for (int i = 0; i < 64 && (m_t % 32) != 0; i++) cyc();
      t0 = m_t;
      for (int k = 0; k < 32; k++) begin
         cyc();
         rel = m_t - t0;
         if (rel % 8 == 4) begin
            s = rel / 8;
            check("digit_seg", seg, exp_seg[s]);
            check("digit_an", {4'h0, an}, {4'h0, lit_mask[s] ? ~(4'b0001 << s) : 4'hF});
         end
      end
   endtask

   initial begin
      vecs[0] = '{16'h0000, 4'b0000, 4'b0000, -1, {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4'b1111};
      vecs[1] = '{16'h1A8F, 4'b0100, 4'b0000, 10, {8'hF9, 8'h08, 8'h80, 8'h8E}, 4'b1111};
      vecs[2] = '{16'h2222, 4'b0000, 4'b0000, 31, {8'hA4, 8'hA4, 8'hA4, 8'hA4}, 4'b1111};
      vecs[3] = '{16'h4567, 4'b0000, 4'b1010, 5,  {8'hFF, 8'h92, 8'hFF, 8'hF8}, 4'b0101};

      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;

      for (int v = 0; v < 4; v++) begin
         if (vecs[v].load_off >= 0) begin
            run_to(vecs[v].load_off);
            do_load(vecs[v].value, vecs[v].dp, vecs[v].blank);
         end
         check_frame(vecs[v].exp_seg, vecs[v].lit_mask);
      end

      // Two loads in one frame: only the later one is displayed.
      run_to(3);
      do_load(16'h1111, 4'b0000, 4'b0000);
      run_to(20);
      do_load(16'h3333, 4'b0000, 4'b0000);
      check_frame({8'hB0, 8'hB0, 8'hB0, 8'hB0}, 4'b1111);

      // Reset during slot 2 ON with a pending shadow load that must be discarded.
      run_to(10);
      do_load(16'h5555, 4'b1111, 4'b0000);
      run_to(19);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("rst_an", {4'h0, an}, 8'h0F);
      check("rst_seg", seg, 8'hFF);
      check("rst_ft", {7'h0, frame_tick}, 8'h00);
      cyc();
      cyc();
      cyc();
      check("restart_seg", seg, 8'hC0);
      check("restart_an", {4'h0, an}, 8'h0E);
      check_frame({8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4'b1111);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream display stage for the Nexys3 demo top. It consumes a 16-bit hex value plus per-digit decimal-point and blank masks from the game/physics logic. It time-multiplexes the four-digit common-anode seven-segment display on `seg`/`an`. Inter-digit blanking suppresses ghosting, and new values are taken frame-coherently so a digit never tears mid-scan.

Parameters:
- DIGIT_TICKS, 100000, gclk cycles per digit slot (100 MHz -> 1 kHz per digit, 250 Hz frame); must be >= 4.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must satisfy 1 <= BLANK_CYCLES < DIGIT_TICKS.

Ports:
- gclk  in  1  system clock (100 MHz)
- reset  in  1  synchronous, active-high reset
- value  in  16  hex value; digit0 = value[3:0] (rightmost, an[0]) ... digit3 = value[15:12]
- dp_in  in  4  decimal point per digit, 1 = lit
- blank_in  in  4  per-digit blank, 1 = digit dark (dp also dark)
- load  in  1  single-cycle strobe; captures value/dp_in/blank_in into shadow registers
- seg  out  8  active-low cathodes: seg[0]=a ... seg[6]=g, seg[7]=dp
- an  out  4  active-low anodes
- frame_tick  out  1  one-cycle pulse when the active registers update (start of digit0 slot)

Behaviour:
- Clocking: one clock, gclk; reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - seg=8'hFF, an=4'b1111, frame_tick=0.
  - Slot counter=0, digit index=0, state=BLANK.
  - Shadow and active registers all 0, except blank=4'b0000.
  - The first frame therefore shows "0000".
- Registers:
  - Shadow {value, dp, blank}: written on any cycle with load=1. The last load before the transfer wins.
  - Active set: copied from shadow at frame start. Frame start is the cycle the counter wraps DIGIT_TICKS-1 -> 0 while the digit index wraps 3 -> 0.
  - Load coinciding with the transfer cycle: the active set takes the load inputs directly (bypass), not the stale shadow.
- Slot counter: 0..DIGIT_TICKS-1, wraps to 0. At each wrap the digit index increments mod 4 (3 -> 0).
- FSM, per slot:
  - BLANK: counter 0..BLANK_CYCLES-1. an=4'b1111, seg=8'hFF.
  - ON: counter BLANK_CYCLES..DIGIT_TICKS-1. an = ~(4'b0001 << idx). seg = {~dp[idx], hex7(nibble[idx])}.
  - If blank[idx]=1, ON drives an=4'b1111, seg=8'hFF.
  - Transitions: BLANK -> ON when counter == BLANK_CYCLES-1. ON -> BLANK when counter == DIGIT_TICKS-1.
- Outputs are registered, so seg/an change on the clock edge after the counter condition. The first ON output appears BLANK_CYCLES+1 cycles after slot start, including the first slot after reset.
- hex7 table (active-low, seg[6:0] = g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- frame_tick: asserted for exactly the one cycle in which the active set is updated. Its first assertion is at the first frame wrap after reset, not at reset.
- Mid-operation reset: reset asserted on any cycle returns all state to the reset values on the next edge. Shadow contents are lost and no partial frame completes.
- Anode one-hot invariant: an never has more than one bit low. an and the active digit never change in the same cycle as a lit segment pattern switches to another digit, guaranteed by BLANK >= 1 cycle.

Test Plan:
All tests use DIGIT_TICKS=8, BLANK_CYCLES=2, so frame = 32 cycles.
1. Reset -> the first 2 cycles of each slot show an=1111/seg=FF. Slot0 ON shows an=1110, seg=C0. All four digits show C0 in rotation 1110, 1101, 1011, 0111.
2. load with value=16'h1A8F, dp_in=4'b0100, blank_in=0 mid-frame -> display unchanged until frame_tick. The next frame shows digit0 seg=8E, digit1 seg=80, digit2 seg=08 with seg[7]=0 (dp lit), digit3 seg=F9.
3. load on the exact frame-wrap cycle with value=16'h2222 -> that same frame shows 24 (with dp off, seg=A4) on all digits; no stale frame.
4. blank_in=4'b1010 -> an stays 1111 and seg=FF during the ON phase of slots 1 and 3. Slots 0 and 2 are lit normally.
5. Two loads (16'h1111, then 16'h3333) within one frame -> the next frame shows 3 (seg=B0) only. frame_tick is high exactly one cycle every 32 cycles.
6. reset asserted during slot 2 ON -> the next cycle gives an=1111, seg=FF, frame_tick=0. Display restarts at digit0 showing 0 (seg=C0) after 3 cycles.
